// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-zero constant and default parameter values.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } ctrlState_t;

  localparam logic [4:0] REG_ZERO               = 5'd0;
  localparam int         CNT_W_DEFAULT          = 16;
  localparam int         MULDIV_LATENCY_DEFAULT = 4;

  // Occupancy counter width; never narrower than one bit so latency 1 still elaborates.
  function automatic int countWidth(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID.
module load_use_detect
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_WriteReg,
  output logic       LoadUse
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign LoadUse = EX_MemRead && EX_RegWrite && (EX_WriteReg != REG_ZERO) &&
                   ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                    (ID_UsesRt && (ID_Rt == EX_WriteReg)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, multi-cycle mul/div occupancy of EX, memory freezes, perf counters.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEFAULT,
  parameter int CNT_W          = CNT_W_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_MulDiv,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  input  logic             MemStall,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Write,
  output logic             EXMEM_Bubble,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int COUNT_W = countWidth(MULDIV_LATENCY);
  localparam logic [COUNT_W-1:0] COUNT_INIT =
    (MULDIV_LATENCY > 1) ? COUNT_W'(MULDIV_LATENCY - 2) : '0;

  ctrlState_t       state, nextState;
  logic [COUNT_W-1:0] count, nextCount;
  logic             loadUse;
  logic             branchFlush;

  load_use_detect u_loadUse (
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .ID_UsesRs  (ID_UsesRs),
    .ID_UsesRt  (ID_UsesRt),
    .EX_MemRead (EX_MemRead),
    .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg),
    .LoadUse    (loadUse)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Bubble  = 1'b0;
    EXMEM_Write  = 1'b1;
    EXMEM_Bubble = 1'b0;
    Busy         = 1'b0;
    nextState    = state;
    nextCount    = count;
    branchFlush  = 1'b0;

    if (Reset) begin
      PCWrite      = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Bubble  = 1'b1;
      EXMEM_Bubble = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (MemStall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
          end else if (EX_BranchTaken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            branchFlush = 1'b1;
          end else if (loadUse) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
          end else if (ID_MulDiv && (MULDIV_LATENCY > 1)) begin
            nextState = ST_MULDIV;
            nextCount = COUNT_INIT;
          end
        end
        // Every MULDIV cycle is a stall; the mul/div's last EX cycle happens back in RUN.
        ST_MULDIV: begin
          Busy = 1'b1;
          if (MemStall) begin
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMEM_Write = 1'b0;
          end else begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            if (count == '0) nextState = ST_RUN;
            else             nextCount = count - COUNT_W'(1);
          end
        end
        default: nextState = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= ST_RUN;
      count       <= '0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      state <= nextState;
      count <= nextCount;
      if (!PCWrite && (StallCycles != '1)) StallCycles <= StallCycles + CNT_W'(1);
      if (branchFlush && (FlushCount != '1)) FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: load-use, branch, mul/div
// occupancy, memory freeze, async reset and counter saturation.
module tb_pipeline_hazard_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WriteReg;
  logic        ID_UsesRs, ID_UsesRt, ID_MulDiv;
  logic        EX_MemRead, EX_RegWrite, EX_BranchTaken, MemStall;

  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble;
  logic        EXMEM_Write, EXMEM_Bubble, Busy;
  logic [15:0] StallCycles, FlushCount;

  logic        nPCWrite, nIFID_Write, nIFID_Flush, nIDEX_Write, nIDEX_Bubble;
  logic        nEXMEM_Write, nEXMEM_Bubble, nBusy;
  logic [3:0]  nStallCycles, nFlushCount;

  logic [7:0]  ctrl;
  int          total = 0;
  int          bad = 0;
  int          expStall = 0;
  int          expFlush = 0;

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write, EXMEM_Bubble, Busy}
  localparam logic [7:0] C_DEF    = 8'b1101_0100;
  localparam logic [7:0] C_RST    = 8'b0011_1110;
  localparam logic [7:0] C_LU     = 8'b0001_1100;
  localparam logic [7:0] C_BR     = 8'b1111_1100;
  localparam logic [7:0] C_FRZ    = 8'b0000_0000;
  localparam logic [7:0] C_MDFRZ  = 8'b0000_0001;
  localparam logic [7:0] C_MDSTL  = 8'b0000_0111;

  assign ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
                 EXMEM_Write, EXMEM_Bubble, Busy};

  always #5 Clock = ~Clock;

  pipeline_hazard_controller #(.MULDIV_LATENCY(4), .CNT_W(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken), .MemStall(MemStall),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write),
    .EXMEM_Bubble(EXMEM_Bubble), .Busy(Busy),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  pipeline_hazard_controller #(.MULDIV_LATENCY(4), .CNT_W(4)) dutNarrow (
    .Clock(Clock), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_MulDiv(ID_MulDiv), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken), .MemStall(MemStall),
    .PCWrite(nPCWrite), .IFID_Write(nIFID_Write), .IFID_Flush(nIFID_Flush),
    .IDEX_Write(nIDEX_Write), .IDEX_Bubble(nIDEX_Bubble), .EXMEM_Write(nEXMEM_Write),
    .EXMEM_Bubble(nEXMEM_Bubble), .Busy(nBusy),
    .StallCycles(nStallCycles), .FlushCount(nFlushCount)
  );

  task automatic idle();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_MulDiv = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteReg = 5'd0;
    EX_BranchTaken = 1'b0; MemStall = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_ex(input logic [4:0] wr);
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteReg = wr;
  endtask

  task automatic test_reset();
    idle();
    Reset = 1'b1;
    #2;
    total++; if (ctrl !== C_RST) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_RST); end
    tick(); tick();
    total++; if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", StallCycles, FlushCount);
    end
    Reset = 1'b0;
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL reset_release_ctrl got=%b want=%b", ctrl, C_DEF); end
    tick();
    total++; if (StallCycles !== 16'd0) begin bad++; $display("FAIL idle_no_count got=%0d want=0", StallCycles); end
  endtask

  task automatic test_load_use();
    load_ex(5'd8); ID_Rs = 5'd8; ID_UsesRs = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_LU) begin bad++; $display("FAIL load_use_rs got=%b want=%b", ctrl, C_LU); end
    tick(); idle(); expStall++;
    total++; if (StallCycles !== 16'(expStall)) begin bad++; $display("FAIL load_use_rs_count got=%0d want=%0d", StallCycles, expStall); end
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL load_use_after got=%b want=%b", ctrl, C_DEF); end
    tick();
    load_ex(5'd17); ID_Rs = 5'd3; ID_UsesRs = 1'b1; ID_Rt = 5'd17; ID_UsesRt = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_LU) begin bad++; $display("FAIL load_use_rt got=%b want=%b", ctrl, C_LU); end
    tick(); idle(); expStall++;
    total++; if (StallCycles !== 16'(expStall)) begin bad++; $display("FAIL load_use_rt_count got=%0d want=%0d", StallCycles, expStall); end
  endtask

  task automatic test_no_stall();
    load_ex(5'd0); ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL no_stall_r0 got=%b want=%b", ctrl, C_DEF); end
    tick(); idle();
    load_ex(5'd8); ID_Rs = 5'd8; ID_UsesRs = 1'b0;
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL no_stall_unused got=%b want=%b", ctrl, C_DEF); end
    tick(); idle();
    EX_MemRead = 1'b1; EX_WriteReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL no_stall_noregwrite got=%b want=%b", ctrl, C_DEF); end
    tick(); idle();
    total++; if (StallCycles !== 16'(expStall)) begin bad++; $display("FAIL no_stall_count got=%0d want=%0d", StallCycles, expStall); end
  endtask

  task automatic test_branch();
    load_ex(5'd8); ID_Rs = 5'd8; ID_UsesRs = 1'b1; ID_MulDiv = 1'b1; EX_BranchTaken = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_BR) begin bad++; $display("FAIL branch_over_lu got=%b want=%b", ctrl, C_BR); end
    tick(); idle(); expFlush++;
    total++; if (FlushCount !== 16'(expFlush) || StallCycles !== 16'(expStall)) begin
      bad++; $display("FAIL branch_counts got=%0d/%0d want=%0d/%0d", FlushCount, StallCycles, expFlush, expStall);
    end
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL branch_no_muldiv got=%b want=%b", ctrl, C_DEF); end
    tick();
    EX_BranchTaken = 1'b1; MemStall = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_FRZ) begin bad++; $display("FAIL memstall_over_branch got=%b want=%b", ctrl, C_FRZ); end
    tick(); idle(); expStall++;
    total++; if (FlushCount !== 16'(expFlush) || StallCycles !== 16'(expStall)) begin
      bad++; $display("FAIL memstall_counts got=%0d/%0d want=%0d/%0d", FlushCount, StallCycles, expFlush, expStall);
    end
  endtask

  task automatic test_muldiv();
    ID_MulDiv = 1'b1;
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL muldiv_issue got=%b want=%b", ctrl, C_DEF); end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin EX_BranchTaken = 1'b1; load_ex(5'd4); ID_Rs = 5'd4; ID_UsesRs = 1'b1; end
      @(negedge Clock);
      total++; if (ctrl !== C_MDSTL) begin bad++; $display("FAIL muldiv_stall%0d got=%b want=%b", i, ctrl, C_MDSTL); end
      tick(); idle(); expStall++;
    end
    @(negedge Clock);
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL muldiv_done got=%b want=%b", ctrl, C_DEF); end
    total++; if (StallCycles !== 16'(expStall) || FlushCount !== 16'(expFlush)) begin
      bad++; $display("FAIL muldiv_counts got=%0d/%0d want=%0d/%0d", StallCycles, FlushCount, expStall, expFlush);
    end
    tick();
  endtask

  task automatic test_muldiv_memstall();
    logic [7:0] want [6];
    want = '{C_MDSTL, C_MDFRZ, C_MDFRZ, C_MDSTL, C_MDSTL, C_DEF};
    ID_MulDiv = 1'b1;
    tick(); idle();
    for (int i = 0; i < 6; i++) begin
      MemStall = (i == 1 || i == 2);
      @(negedge Clock);
      total++; if (ctrl !== want[i]) begin bad++; $display("FAIL muldiv_mem%0d got=%b want=%b", i, ctrl, want[i]); end
      tick(); idle();
    end
    expStall += 5;
    total++; if (StallCycles !== 16'(expStall)) begin bad++; $display("FAIL muldiv_mem_count got=%0d want=%0d", StallCycles, expStall); end
  endtask

  task automatic test_reset_mid_muldiv();
    ID_MulDiv = 1'b1;
    tick(); idle();
    @(negedge Clock);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", Busy); end
    tick();
    #2 Reset = 1'b1;
    #1;
    total++; if (ctrl !== C_RST) begin bad++; $display("FAIL async_reset_ctrl got=%b want=%b", ctrl, C_RST); end
    total++; if (StallCycles !== 16'd0 || FlushCount !== 16'd0) begin
      bad++; $display("FAIL async_reset_counters got=%0d/%0d want=0/0", StallCycles, FlushCount);
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL post_reset_run%0d got=%b want=%b", i, ctrl, C_DEF); end
      tick();
    end
    expStall = 0; expFlush = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin MemStall = 1'b1; tick(); end
    idle();
    total++; if (StallCycles !== 16'd20) begin bad++; $display("FAIL stall_wide got=%0d want=20", StallCycles); end
    total++; if (nStallCycles !== 4'd15) begin bad++; $display("FAIL stall_saturate got=%0d want=15", nStallCycles); end
    for (int i = 0; i < 17; i++) begin EX_BranchTaken = 1'b1; tick(); end
    idle();
    total++; if (FlushCount !== 16'd17) begin bad++; $display("FAIL flush_wide got=%0d want=17", FlushCount); end
    total++; if (nFlushCount !== 4'd15 || nStallCycles !== 4'd15) begin
      bad++; $display("FAIL flush_saturate got=%0d/%0d want=15/15", nFlushCount, nStallCycles);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_muldiv();
    test_muldiv_memstall();
    test_reset_mid_muldiv();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
